// File: rtl/riscy_if_pkg.sv
// Shared fetch-stage types and constants for the Riscy SoC.
package riscy_if_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr} pairs.
module fetch_buf
  import riscy_if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic rd;
  logic wr;
  logic do_pop;
  logic do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (do_pop) rd <= ~rd;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, memory issue, redirect kill and fault detection.
module instr_fetch
  import riscy_if_pkg::*;
#(
  parameter int          MEM_DEPTH = 8001,
  parameter int          IDX_W     = $clog2(MEM_DEPTH),
  parameter logic [31:0] RESET_PC  = riscy_if_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [IDX_W-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             fault
);

  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         inflight;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;
  logic         pc_bad;
  logic         room;
  logic         pop;
  logic         bypass;
  logic         push;

  assign pc_bad = (pc[1:0] != 2'b00) ||
                  ({2'b00, pc[31:2]} >= 32'(MEM_DEPTH));
  assign room   = ({1'b0, count} + {2'b00, inflight}) < 3'd2;
  assign pop    = if_valid && if_ready;

  assign imem_req  = !rst && !fault && !pc_bad &&
                     !redirect_valid && (room || pop);
  assign imem_addr = pc[IDX_W+1:2];

  // An empty queue exposes the arriving response directly to decode.
  assign bypass   = (count == 2'd0) && inflight;
  assign if_valid = (count != 2'd0) || inflight;
  assign if_instr = bypass ? imem_rdata : head.instr;
  assign if_pc    = bypass ? req_pc : head.pc;

  assign push = inflight && !redirect_valid && !(pop && bypass);
  assign din  = '{pc: req_pc, instr: imem_rdata};

  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop && !bypass),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      fault    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (imem_req) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (!redirect_valid && pc_bad) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random checks of instr_fetch against an in-order PC model.
module tb_instr_fetch;

  localparam int DEPTH = 8001;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;

  int checks   = 0;
  int failures = 0;
  int n_req    = 0;
  int r0;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] exp_pc;
  logic [31:0] nf;
  logic [31:0] last_pop;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) begin
      if (int'(imem_addr) < DEPTH) imem_rdata <= mem[imem_addr];
      else imem_rdata <= 32'hdead_beef;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score a pop against the model, then advance the model.
  task automatic step();
    logic rv, pp, rq, rs;
    logic [31:0] rp;
    #1;
    rs = rst;
    rv = redirect_valid;
    rp = redirect_pc;
    pp = if_valid && if_ready;
    rq = imem_req;
    if (!rs) begin
      if (pp) begin
        chk("sb_pc", if_pc, exp_pc);
        chk("sb_instr", if_instr, mem[exp_pc >> 2]);
        last_pop = if_pc;
      end
      if (rq) begin
        n_req++;
        chk("sb_addr", {19'h0, imem_addr}, {19'h0, nf[14:2]});
      end
    end
    @(posedge clk);
    if (!rs) begin
      if (pp) exp_pc = exp_pc + 32'd4;
      if (rq) nf = nf + 32'd4;
      if (rv) begin
        exp_pc = rp;
        nf     = rp;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    repeat (2) step();
    exp_pc = 32'h0;
    nf     = 32'h0;
    rst    = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    imem_rdata     = 32'h0;
    exp_pc         = 32'h0;
    nf             = 32'h0;
    last_pop       = 32'h0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h13 + 32'h80 * i;

    // Reset state
    @(negedge clk);
    step();
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);

    // Free run from reset
    rst      = 1'b0;
    if_ready = 1'b1;
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("run_valid", {31'h0, if_valid}, 32'h1);
      chk("run_pc", if_pc, 32'(4 * k));
      chk("run_instr", if_instr, 32'h13 + 32'h80 * k);
      step();
    end

    // Backpressure
    do_reset();
    r0 = n_req;
    repeat (5) step();
    chk("bp_reqs", 32'(n_req - r0), 32'd2);
    chk("bp_req_low", {31'h0, imem_req}, 32'h0);
    chk("bp_valid", {31'h0, if_valid}, 32'h1);
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rel_valid", {31'h0, if_valid}, 32'h1);
      chk("bp_rel_pc", if_pc, 32'(4 * k));
      step();
    end

    // Redirect with one queued and one in flight
    do_reset();
    repeat (2) step();
    chk("rd_pre_valid", {31'h0, if_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("rd_t_req", {31'h0, imem_req}, 32'h0);
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    #1;
    chk("rd_t1_valid", {31'h0, if_valid}, 32'h0);
    chk("rd_t1_req", {31'h0, imem_req}, 32'h1);
    chk("rd_t1_addr", {19'h0, imem_addr}, 32'h10);
    step();
    chk("rd_t2_valid", {31'h0, if_valid}, 32'h1);
    chk("rd_t2_pc", if_pc, 32'h40);

    // Random ready and redirects against the model
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 32'($urandom_range(0, 6000)) << 2;
      step();
    end
    redirect_valid = 1'b0;

    // Run off the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'(4 * 7996);
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    repeat (15) step();
    chk("end_last_pc", last_pop, 32'h7D00);
    chk("end_fault", {31'h0, fault}, 32'h1);
    chk("end_valid", {31'h0, if_valid}, 32'h0);
    chk("end_req", {31'h0, imem_req}, 32'h0);

    // Misaligned redirect
    do_reset();
    if_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("mis_req", {31'h0, imem_req}, 32'h0);
    chk("mis_valid1", {31'h0, if_valid}, 32'h0);
    step();
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_valid2", {31'h0, if_valid}, 32'h0);
    r0 = n_req;
    repeat (3) step();
    chk("mis_no_req", 32'(n_req - r0), 32'd0);

    // Reset mid-stream with a full queue
    do_reset();
    repeat (4) step();
    chk("mid_full", {31'h0, if_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_req", {31'h0, imem_req}, 32'h0);
    chk("mid_fault", {31'h0, fault}, 32'h0);
    do_reset();
    if_ready = 1'b1;
    #1;
    chk("mid_req_pc", {19'h0, imem_addr}, 32'h0);
    step();
    chk("mid_restart_valid", {31'h0, if_valid}, 32'h1);
    chk("mid_restart_pc", if_pc, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
